// File: rtl/roi_band_centroid_if.sv
// Pixel-stream input and band-result output bundle for roi_band_centroid.
// The slave modport is the tracker itself; master is whoever feeds pixels and consumes results.
interface roi_band_centroid_if #(
    parameter int IMG_W      = 640,
    parameter int PIX_W      = 4,
    parameter int ROI_HEIGHT = 32,
    parameter int NUM_ROI    = 2
);
    localparam int XW = $clog2(IMG_W);
    localparam int CW = $clog2(ROI_HEIGHT * IMG_W + 1);
    localparam int RW = (NUM_ROI > 1) ? $clog2(NUM_ROI) : 1;

    logic             in_valid;
    logic             sof;
    logic [PIX_W-1:0] pixel_in;
    logic [PIX_W-1:0] thr;
    logic             res_valid;
    logic             res_ready;
    logic [RW-1:0]    res_roi;
    logic [XW-1:0]    res_x;
    logic [CW-1:0]    res_count;
    logic             res_lost;
    logic             overrun;
    logic             frame_done;

    modport master (
        output in_valid, sof, pixel_in, thr, res_ready,
        input  res_valid, res_roi, res_x, res_count, res_lost, overrun, frame_done
    );

    modport slave (
        input  in_valid, sof, pixel_in, thr, res_ready,
        output res_valid, res_roi, res_x, res_count, res_lost, overrun, frame_done
    );
endinterface

// File: rtl/roi_band_centroid.sv
// Per-band x-centroid of above-threshold pixels, serial restoring divide, one
// valid/ready result per band per frame with lost-line and overrun reporting.
module roi_band_centroid #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int PIX_W      = 4,
    parameter int ROI_HEIGHT = 32,
    parameter int NUM_ROI    = 2,
    parameter int MIN_PIXELS = 8
) (
    input  logic               clk,
    input  logic               rst,
    roi_band_centroid_if.slave bus
);
    localparam int XW  = $clog2(IMG_W);
    localparam int YW  = $clog2(IMG_H);
    localparam int YW1 = YW + 1;
    localparam int CW  = $clog2(ROI_HEIGHT * IMG_W + 1);
    localparam int SW  = $clog2(ROI_HEIGHT * IMG_W * IMG_W);
    localparam int RW  = (NUM_ROI > 1) ? $clog2(NUM_ROI) : 1;
    localparam int STW = $clog2(SW + 1);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_HOLD} state_t;

    // ---------------- raster position ----------------
    logic [XW-1:0] col_reg;
    logic [XW-1:0] cur_col;
    logic [YW-1:0] row_reg;
    logic [YW-1:0] cur_row;
    logic          last_col;
    logic          last_line;

    assign cur_col   = bus.sof ? '0 : col_reg;
    assign cur_row   = bus.sof ? '0 : row_reg;
    assign last_col  = (cur_col == XW'(IMG_W - 1));
    assign last_line = (cur_row == YW'(IMG_H - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (bus.in_valid) begin
            if (last_col) begin
                col_reg <= '0;
                row_reg <= last_line ? '0 : cur_row + YW'(1);
            end else begin
                col_reg <= cur_col + XW'(1);
                row_reg <= cur_row;
            end
        end
    end

    // ---------------- band membership ----------------
    // rel_row counts rows up from the image bottom; band gi owns rel rows
    // gi*ROI_HEIGHT .. gi*ROI_HEIGHT+ROI_HEIGHT-1, and its raster-last row is off==0.
    logic [YW:0]        rel_row;
    logic [NUM_ROI-1:0] in_band;
    logic [NUM_ROI-1:0] band_last;
    logic [RW-1:0]      band_idx;

    assign rel_row = YW1'(IMG_H - 1) - {1'b0, cur_row};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ROI; gi++) begin : g_band
            logic [YW:0] off;
            assign off           = rel_row - YW1'(gi * ROI_HEIGHT);
            assign in_band[gi]   = (off < YW1'(ROI_HEIGHT));
            assign band_last[gi] = (off == '0);
        end
    endgenerate

    always_comb begin
        band_idx = '0;
        for (int k = 0; k < NUM_ROI; k++) begin
            if (in_band[k]) band_idx = RW'(k);
        end
    end

    // ---------------- accumulation ----------------
    logic [SW-1:0] sum_reg;
    logic [SW-1:0] fin_sum;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] fin_cnt;
    logic          hit;
    logic          cpl;
    logic          enough;

    assign hit     = bus.in_valid && (|in_band) && (bus.pixel_in > bus.thr);
    assign fin_sum = (bus.sof ? '0 : sum_reg) + (hit ? SW'(cur_col) : '0);
    assign fin_cnt = (bus.sof ? '0 : cnt_reg) + CW'(hit);
    // sof forces position (0,0), which can never close a band
    assign cpl     = bus.in_valid && !bus.sof && last_col && (|band_last);
    assign enough  = (fin_cnt >= CW'(MIN_PIXELS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_reg <= '0;
            cnt_reg <= '0;
        end else if (cpl) begin
            sum_reg <= '0;
            cnt_reg <= '0;
        end else if (bus.in_valid) begin
            sum_reg <= fin_sum;
            cnt_reg <= fin_cnt;
        end
    end

    // ---------------- restoring divider step ----------------
    logic [SW-1:0]  dq_reg;
    logic [SW-1:0]  dq_next;
    logic [CW-1:0]  rem_reg;
    logic [CW-1:0]  rem_next;
    logic [CW-1:0]  cnt_lat_reg;
    logic [RW-1:0]  roi_lat_reg;
    logic [STW-1:0] step_reg;
    logic [CW:0]    trial;
    logic [CW:0]    diff;
    logic           qbit;

    // dq_reg shifts dividend bits out at the top and quotient bits in at the bottom
    assign trial    = {rem_reg, dq_reg[SW-1]};
    assign diff     = trial - {1'b0, cnt_lat_reg};
    assign qbit     = !diff[CW];
    assign rem_next = qbit ? diff[CW-1:0] : trial[CW-1:0];
    assign dq_next  = {dq_reg[SW-2:0], qbit};

    // ---------------- result FSM ----------------
    state_t        state_reg;
    logic          res_valid_reg;
    logic [RW-1:0] res_roi_reg;
    logic [XW-1:0] res_x_reg;
    logic [CW-1:0] res_count_reg;
    logic          res_lost_reg;
    logic          overrun_reg;
    logic          accept;

    assign accept = cpl && ((state_reg == S_IDLE) ||
                            ((state_reg == S_HOLD) && bus.res_ready));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            res_valid_reg <= 1'b0;
            res_roi_reg   <= '0;
            res_x_reg     <= '0;
            res_count_reg <= '0;
            res_lost_reg  <= 1'b0;
            overrun_reg   <= 1'b0;
            dq_reg        <= '0;
            rem_reg       <= '0;
            cnt_lat_reg   <= '0;
            roi_lat_reg   <= '0;
            step_reg      <= '0;
        end else begin
            if (bus.in_valid && bus.sof) begin
                overrun_reg <= 1'b0;
            end else if (cpl && !accept) begin
                overrun_reg <= 1'b1;
            end

            case (state_reg)
                S_DIV: begin
                    dq_reg   <= dq_next;
                    rem_reg  <= rem_next;
                    step_reg <= step_reg + STW'(1);
                    if (step_reg == STW'(SW - 1)) begin
                        state_reg     <= S_HOLD;
                        res_valid_reg <= 1'b1;
                        res_x_reg     <= dq_next[XW-1:0];
                        res_count_reg <= cnt_lat_reg;
                        res_roi_reg   <= roi_lat_reg;
                        res_lost_reg  <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (bus.res_ready) begin
                        state_reg     <= S_IDLE;
                        res_valid_reg <= 1'b0;
                    end
                end
                default: ;
            endcase

            // a completion in the transfer cycle is served exactly as in IDLE
            if (accept) begin
                if (enough) begin
                    state_reg     <= S_DIV;
                    res_valid_reg <= 1'b0;
                    dq_reg        <= fin_sum;
                    rem_reg       <= '0;
                    cnt_lat_reg   <= fin_cnt;
                    roi_lat_reg   <= band_idx;
                    step_reg      <= '0;
                end else begin
                    state_reg     <= S_HOLD;
                    res_valid_reg <= 1'b1;
                    res_x_reg     <= '0;
                    res_count_reg <= fin_cnt;
                    res_roi_reg   <= band_idx;
                    res_lost_reg  <= 1'b1;
                end
            end
        end
    end

    assign bus.res_valid  = res_valid_reg;
    assign bus.res_roi    = res_roi_reg;
    assign bus.res_x      = res_x_reg;
    assign bus.res_count  = res_count_reg;
    assign bus.res_lost   = res_lost_reg;
    assign bus.overrun    = overrun_reg;
    assign bus.frame_done = bus.in_valid && last_col && last_line;
endmodule

// File: tb/tb_roi_band_centroid.sv
// Bench for roi_band_centroid: table vectors, random frames against a per-band
// arithmetic model, and hand sequences for backpressure, reset and sof abort.
module tb_roi_band_centroid;
    localparam int IMG_W      = 16;
    localparam int IMG_H      = 8;
    localparam int PIX_W      = 4;
    localparam int ROI_HEIGHT = 2;
    localparam int NUM_ROI    = 2;
    localparam int MIN_PIXELS = 1;
    localparam int SW         = $clog2(ROI_HEIGHT * IMG_W * IMG_W);
    localparam int NPIX       = IMG_W * IMG_H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    roi_band_centroid_if #(.IMG_W(IMG_W), .PIX_W(PIX_W), .ROI_HEIGHT(ROI_HEIGHT),
                           .NUM_ROI(NUM_ROI)) bus ();

    roi_band_centroid #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W),
                        .ROI_HEIGHT(ROI_HEIGHT), .NUM_ROI(NUM_ROI),
                        .MIN_PIXELS(MIN_PIXELS)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct { int roi; int x; int cnt; int lost; int lat; } res_t;
    typedef struct { int ca; int va; int cb; int vb; int thr; int ex; int ecnt; int elost; } vec_t;

    res_t got_q[$];
    res_t exp_q[$];
    int   cpl_q[$];
    int   frame [IMG_H][IMG_W];
    int   checks = 0;
    int   failures = 0;
    int   fd_cnt = 0;
    int   cyc = 0;
    int   beat_cyc = 0;
    int   start_cyc = 0;
    bit   prev_v = 1'b0;
    bit   prev_x = 1'b0;
    res_t snap;
    res_t cur;
    vec_t vecs[6];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // result monitor: records transfers with the cycle their res_valid first rose
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
            prev_x = 1'b0;
        end else begin
            cur.roi  = int'(bus.res_roi);
            cur.x    = int'(bus.res_x);
            cur.cnt  = int'(bus.res_count);
            cur.lost = int'(bus.res_lost);
            if (bus.frame_done) fd_cnt++;
            if (bus.res_valid && (!prev_v || prev_x)) start_cyc = cyc;
            if (bus.res_valid && prev_v && !prev_x) begin
                chk("hold_stable_roi", cur.roi, snap.roi);
                chk("hold_stable_x", cur.x, snap.x);
                chk("hold_stable_count", cur.cnt, snap.cnt);
                chk("hold_stable_lost", cur.lost, snap.lost);
            end
            cur.lat = start_cyc;
            if (bus.res_valid && bus.res_ready) begin
                got_q.push_back(cur);
                $display("xfer roi=%0d x=%0d count=%0d lost=%0d valid_cyc=%0d",
                         cur.roi, cur.x, cur.cnt, cur.lost, start_cyc);
            end
            prev_v = bus.res_valid;
            prev_x = bus.res_valid && bus.res_ready;
            snap   = cur;
        end
    end

    function automatic bit band_last_row(input int r);
        for (int k = 0; k < NUM_ROI; k++) begin
            if (r == IMG_H - 1 - k * ROI_HEIGHT) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic drive_beat(input int p, input bit s);
        bus.in_valid = 1'b1;
        bus.sof      = s;
        bus.pixel_in = PIX_W'(p);
        beat_cyc     = cyc;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.sof      = 1'b0;
    endtask

    // raster-order beats from (0,0); records the cycle of each band-closing beat
    task automatic run_frame(input int nbeats, input int gap_max);
        cpl_q.delete();
        for (int i = 0; i < nbeats; i++) begin
            int r;
            int c;
            r = i / IMG_W;
            c = i % IMG_W;
            drive_beat(frame[r][c], i == 0);
            if (c == IMG_W - 1 && band_last_row(r)) cpl_q.push_back(beat_cyc);
            if (gap_max > 0) begin
                repeat ($urandom_range(gap_max, 0)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    function automatic void fill_pattern(input int ca, input int va, input int cb, input int vb);
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) frame[r][c] = 0;
            if (ca >= 0) frame[r][ca] = va;
            if (cb >= 0) frame[r][cb] = vb;
        end
    endfunction

    function automatic void expect_table(input vec_t v);
        for (int k = NUM_ROI - 1; k >= 0; k--) begin
            res_t e;
            e.roi  = k;
            e.x    = v.ex;
            e.cnt  = v.ecnt;
            e.lost = v.elost;
            e.lat  = (v.elost != 0) ? 1 : SW + 1;
            exp_q.push_back(e);
        end
    endfunction

    // reference: per-band hit count and column sum straight from the frame array
    function automatic void model_frame(input int t);
        for (int k = NUM_ROI - 1; k >= 0; k--) begin
            res_t e;
            int s;
            int n;
            s = 0;
            n = 0;
            for (int r = IMG_H - (k + 1) * ROI_HEIGHT; r <= IMG_H - k * ROI_HEIGHT - 1; r++) begin
                for (int c = 0; c < IMG_W; c++) begin
                    if (frame[r][c] > t) begin
                        s += c;
                        n++;
                    end
                end
            end
            e.roi  = k;
            e.cnt  = n;
            e.lost = (n < MIN_PIXELS) ? 1 : 0;
            e.x    = (e.lost != 0) ? 0 : s / n;
            e.lat  = (e.lost != 0) ? 1 : SW + 1;
            exp_q.push_back(e);
        end
    endfunction

    task automatic compare_results(input string tag);
        int waited;
        waited = 0;
        while (got_q.size() < exp_q.size() && waited < 400) begin
            @(posedge clk);
            #1;
            waited++;
        end
        repeat (SW + 4) @(posedge clk);
        #1;
        chk({tag, "_num_results"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s_r%0d_roi", tag, i), got_q[i].roi, exp_q[i].roi);
            chk($sformatf("%s_r%0d_x", tag, i), got_q[i].x, exp_q[i].x);
            chk($sformatf("%s_r%0d_count", tag, i), got_q[i].cnt, exp_q[i].cnt);
            chk($sformatf("%s_r%0d_lost", tag, i), got_q[i].lost, exp_q[i].lost);
            if (i < cpl_q.size())
                chk($sformatf("%s_r%0d_latency", tag, i), got_q[i].lat - cpl_q[i], exp_q[i].lat);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // {col_a, val_a, col_b, val_b, thr, x, count, lost}; both bands identical
        vecs[0] = '{5, 15, 6, 15, 0, 5, 4, 0};
        vecs[1] = '{-1, 0, -1, 0, 0, 0, 0, 1};
        vecs[2] = '{3, 7, 9, 8, 7, 9, 2, 0};
        vecs[3] = '{0, 1, 15, 1, 0, 7, 4, 0};
        vecs[4] = '{15, 9, -1, 0, 8, 15, 2, 0};
        vecs[5] = '{1, 3, 2, 3, 3, 0, 0, 1};

        bus.in_valid  = 1'b0;
        bus.sof       = 1'b0;
        bus.pixel_in  = '0;
        bus.thr       = '0;
        bus.res_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_res_valid", int'(bus.res_valid), 0);
        chk("reset_res_x", int'(bus.res_x), 0);
        chk("reset_res_count", int'(bus.res_count), 0);
        chk("reset_res_lost", int'(bus.res_lost), 0);
        chk("reset_res_roi", int'(bus.res_roi), 0);
        chk("reset_overrun", int'(bus.overrun), 0);
        chk("reset_frame_done", int'(bus.frame_done), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            int fd0;
            fill_pattern(vecs[i].ca, vecs[i].va, vecs[i].cb, vecs[i].vb);
            bus.thr = PIX_W'(vecs[i].thr);
            fd0 = fd_cnt;
            run_frame(NPIX, (i % 2) * 2);
            expect_table(vecs[i]);
            compare_results($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_frame_done_pulses", i), fd_cnt - fd0, 1);
        end

        for (int f = 0; f < 8; f++) begin
            int t;
            int dens;
            dens = $urandom_range(4, 0);
            t    = $urandom_range(14, 0);
            for (int r = 0; r < IMG_H; r++)
                for (int c = 0; c < IMG_W; c++)
                    frame[r][c] = ($urandom_range(7, 0) < dens) ? $urandom_range(15, 0) : 0;
            bus.thr = PIX_W'(t);
            run_frame(NPIX, f % 3);
            model_frame(t);
            compare_results($sformatf("rand%0d", f));
        end

        // backpressure: band 1 held for the whole frame, band 0 dropped
        fill_pattern(5, 15, 6, 15);
        bus.thr = '0;
        bus.res_ready = 1'b0;
        run_frame(NPIX, 0);
        repeat (SW + 4) @(posedge clk);
        #1;
        chk("bp_overrun_set", int'(bus.overrun), 1);
        chk("bp_res_valid_held", int'(bus.res_valid), 1);
        chk("bp_res_roi_held", int'(bus.res_roi), 1);
        chk("bp_res_x_held", int'(bus.res_x), 5);
        chk("bp_res_count_held", int'(bus.res_count), 4);
        chk("bp_no_transfer_yet", got_q.size(), 0);
        bus.res_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_single_transfer", got_q.size(), 1);
        if (got_q.size() > 0) chk("bp_transfer_roi", got_q[0].roi, 1);
        chk("bp_res_valid_dropped", int'(bus.res_valid), 0);
        chk("bp_overrun_sticky", int'(bus.overrun), 1);
        got_q.delete();
        drive_beat(0, 1'b1);
        chk("bp_overrun_cleared_by_sof", int'(bus.overrun), 0);

        // reset while band 1 is mid-divide
        run_frame(6 * IMG_W, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("divrst_res_valid", int'(bus.res_valid), 0);
        chk("divrst_res_x", int'(bus.res_x), 0);
        chk("divrst_res_count", int'(bus.res_count), 0);
        chk("divrst_res_roi", int'(bus.res_roi), 0);
        chk("divrst_overrun", int'(bus.overrun), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (SW + 4) @(posedge clk);
        #1;
        chk("divrst_abandoned", got_q.size(), 0);
        got_q.delete();
        run_frame(NPIX, 0);
        expect_table(vecs[0]);
        compare_results("after_rst");

        // sof in the middle of band 1 (row 4, col 8), then a stalled full frame
        run_frame(4 * IMG_W + 8, 0);
        run_frame(NPIX, 3);
        expect_table(vecs[0]);
        compare_results("sof_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
